// File: rtl/zic_pkg.sv
`default_nettype none
//==============================================================================
// Module      : zic_pkg
// Description : Shared constants and FSM state type for the ZIC priority
//               interrupt controller.
// Revision    : 1.0 - initial release
//==============================================================================
package zic_pkg;

    localparam int ID_W         = 8;
    localparam int LP_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } zic_state_e;

endpackage
`default_nettype wire

// File: rtl/zic_prio_tree.sv
`default_nettype none
//==============================================================================
// Module      : zic_prio_tree
// Description : Combinational max-LP comparator tree; ties resolve to the
//               lowest line index.
// Revision    : 1.0 - initial release
//==============================================================================
module zic_prio_tree
    import zic_pkg::*;
#(
    parameter int NUM_IRQ = 64,
    parameter int LP_W    = LP_W_DEFAULT
) (
    input  logic [NUM_IRQ-1:0]      i_cand,
    input  logic [NUM_IRQ*LP_W-1:0] i_lp,
    output logic                    o_valid,
    output logic [LP_W-1:0]         o_lp,
    output logic [ID_W-1:0]         o_id
);

    localparam int c_LEAVES = 2 ** $clog2(NUM_IRQ);
    localparam int c_NODES  = 2 * c_LEAVES - 1;

    // Heap-ordered nodes: node k has children 2k+1 (lower ids) and 2k+2.
    logic            w_vld [c_NODES];
    logic [LP_W-1:0] w_lp  [c_NODES];
    logic [ID_W-1:0] w_id  [c_NODES];

    always_comb begin
        for (int k = 0; k < c_NODES; k++) begin
            w_vld[k] = 1'b0;
            w_lp[k]  = '0;
            w_id[k]  = '0;
        end
        for (int n = 0; n < NUM_IRQ; n++) begin
            w_vld[c_LEAVES-1+n] = i_cand[n];
            w_lp[c_LEAVES-1+n]  = i_lp[n*LP_W +: LP_W];
            w_id[c_LEAVES-1+n]  = ID_W'(n);
        end
        for (int k = c_LEAVES - 2; k >= 0; k--) begin
            // >= keeps the left (lower-index) child on equal priority
            if (w_vld[2*k+1] && (!w_vld[2*k+2] || (w_lp[2*k+1] >= w_lp[2*k+2]))) begin
                w_vld[k] = 1'b1;
                w_lp[k]  = w_lp[2*k+1];
                w_id[k]  = w_id[2*k+1];
            end else if (w_vld[2*k+2]) begin
                w_vld[k] = 1'b1;
                w_lp[k]  = w_lp[2*k+2];
                w_id[k]  = w_id[2*k+2];
            end
        end
    end

    assign o_valid = w_vld[0];
    assign o_lp    = w_lp[0];
    assign o_id    = w_id[0];

endmodule
`default_nettype wire

// File: rtl/zic_prio_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : zic_prio_ctrl
// Description : Prioritised interrupt controller with ack/EOI tracking.
//               Edge-triggered lines are built only when ZIC_EDGE_TRIG_EN
//               is defined; otherwise every line is level mode.
// Revision    : 1.0 - initial release
//==============================================================================
module zic_prio_ctrl
    import zic_pkg::*;
#(
    parameter int NUM_IRQ = 64,
    parameter int LP_W    = LP_W_DEFAULT
) (
    input  logic                    zic_clk,
    input  logic                    zic_rst,
    input  logic [NUM_IRQ-1:0]      irq_i,
    input  logic [NUM_IRQ-1:0]      irq_en_i,
    input  logic [NUM_IRQ-1:0]      irq_edge_i,
    input  logic [NUM_IRQ*LP_W-1:0] irq_lp_i,
    input  logic [LP_W-1:0]         active_lvl_pr_i,
    input  logic                    ack_i,
    input  logic                    eoi_valid_i,
    input  logic [ID_W-1:0]         eoi_id_i,
    output logic                    interrupt_request_o,
    output logic [ID_W-1:0]         interrupt_id_o,
    output logic [ID_W-1:0]         ack_id_o,
    output logic [NUM_IRQ-1:0]      pending_o,
    output logic [NUM_IRQ-1:0]      in_service_o,
    output logic [LP_W-1:0]         highest_pending_lvl_pr_o
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_ack_mask;
    logic [NUM_IRQ-1:0] w_eoi_mask;
    zic_state_e         r_state;
    logic               r_holdoff;
    logic               w_win_valid;
    logic [LP_W-1:0]    w_win_lp;
    logic [ID_W-1:0]    w_win_id;
    logic               w_ack;
    logic               w_above;

    assign w_ack   = ack_i && (r_state == ST_REQ);
    assign w_above = w_win_valid && (w_win_lp > active_lvl_pr_i);

    // Out-of-range EOI ids match no line and therefore have no effect.
    always_comb begin
        w_ack_mask = '0;
        w_eoi_mask = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            w_ack_mask[n] = w_ack && (interrupt_id_o == ID_W'(n));
            w_eoi_mask[n] = eoi_valid_i && (eoi_id_i == ID_W'(n));
        end
    end

`ifdef ZIC_EDGE_TRIG_EN
    logic [NUM_IRQ-1:0] r_edge_pend;

    // A fresh rising edge outranks the ack clear in the same cycle.
    always_ff @(posedge zic_clk or posedge zic_rst) begin
        if (zic_rst) begin
            r_edge_pend <= '0;
        end else begin
            r_edge_pend <= (r_edge_pend & ~w_ack_mask) | (irq_edge_i & irq_i & ~r_irq_q);
        end
    end

    assign w_pending = (irq_edge_i & r_edge_pend) | (~irq_edge_i & r_irq_q & ~r_in_service);
`else
    logic w_unused_edge;
    assign w_unused_edge = ^irq_edge_i;
    assign w_pending     = r_irq_q & ~r_in_service;
`endif

    assign w_cand = w_pending & irq_en_i & ~r_in_service;

    zic_prio_tree #(
        .NUM_IRQ (NUM_IRQ),
        .LP_W    (LP_W)
    ) u_tree (
        .i_cand  (w_cand),
        .i_lp    (irq_lp_i),
        .o_valid (w_win_valid),
        .o_lp    (w_win_lp),
        .o_id    (w_win_id)
    );

    always_ff @(posedge zic_clk or posedge zic_rst) begin
        if (zic_rst) begin
            r_state                  <= ST_IDLE;
            r_holdoff                <= 1'b0;
            r_irq_q                  <= '0;
            r_in_service             <= '0;
            interrupt_request_o      <= 1'b0;
            interrupt_id_o           <= '0;
            ack_id_o                 <= '0;
            highest_pending_lvl_pr_o <= '0;
        end else begin
            r_irq_q                  <= irq_i;
            r_in_service             <= (r_in_service & ~w_eoi_mask) | w_ack_mask;
            highest_pending_lvl_pr_o <= w_win_valid ? w_win_lp : '0;
            interrupt_id_o           <= w_win_valid ? w_win_id : '0;
            r_holdoff                <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // One extra idle cycle after an ack before re-requesting
                    if (w_above && !r_holdoff) begin
                        r_state             <= ST_REQ;
                        interrupt_request_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        ack_id_o            <= interrupt_id_o;
                        r_state             <= ST_IDLE;
                        interrupt_request_o <= 1'b0;
                        r_holdoff           <= 1'b1;
                    end else if (!w_above) begin
                        r_state             <= ST_IDLE;
                        interrupt_request_o <= 1'b0;
                    end
                end
                default: begin
                    r_state             <= ST_IDLE;
                    interrupt_request_o <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o    = w_pending;
    assign in_service_o = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_zic_prio_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_zic_prio_ctrl
// Description : Self-checking bench for zic_prio_ctrl against a cycle-level
//               reference model; edge scenarios need ZIC_EDGE_TRIG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_zic_prio_ctrl;
    import zic_pkg::*;

    localparam int NUM_IRQ = 256;
    localparam int LP_W    = 8;
`ifdef ZIC_EDGE_TRIG_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IRQ-1:0]      irq;
    logic [NUM_IRQ-1:0]      irq_en;
    logic [NUM_IRQ-1:0]      irq_edge;
    logic [NUM_IRQ*LP_W-1:0] irq_lp;
    logic [LP_W-1:0]         active;
    logic                    ack;
    logic                    eoi_valid;
    logic [ID_W-1:0]         eoi_id;
    logic                    req_o;
    logic [ID_W-1:0]         id_o;
    logic [ID_W-1:0]         ack_id_o;
    logic [NUM_IRQ-1:0]      pend_o;
    logic [NUM_IRQ-1:0]      insvc_o;
    logic [LP_W-1:0]         hp_o;

    always #5 clk = ~clk;

    zic_prio_ctrl #(
        .NUM_IRQ (NUM_IRQ),
        .LP_W    (LP_W)
    ) dut (
        .zic_clk                  (clk),
        .zic_rst                  (rst),
        .irq_i                    (irq),
        .irq_en_i                 (irq_en),
        .irq_edge_i               (irq_edge),
        .irq_lp_i                 (irq_lp),
        .active_lvl_pr_i          (active),
        .ack_i                    (ack),
        .eoi_valid_i              (eoi_valid),
        .eoi_id_i                 (eoi_id),
        .interrupt_request_o      (req_o),
        .interrupt_id_o           (id_o),
        .ack_id_o                 (ack_id_o),
        .pending_o                (pend_o),
        .in_service_o             (insvc_o),
        .highest_pending_lvl_pr_o (hp_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state as it should look after the most recent edge.
    logic [NUM_IRQ-1:0] m_irq_q, m_epend, m_insvc;
    logic               m_req;
    logic [ID_W-1:0]    m_id, m_ack_id;
    logic [LP_W-1:0]    m_hp;
    int                 cyc, last_ack;

    logic [NUM_IRQ-1:0] nx_irq_q, nx_epend, nx_insvc;
    logic               nx_req;
    logic [ID_W-1:0]    nx_id, nx_ack_id;
    logic [LP_W-1:0]    nx_hp;
    int                 nx_last_ack;

    task automatic check(input string tag, input logic [NUM_IRQ-1:0] obs, input logic [NUM_IRQ-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_pending(int n);
        if (EDGE_EN && irq_edge[n]) return m_epend[n];
        return m_irq_q[n] && !m_insvc[n];
    endfunction

    task automatic model_reset();
        m_irq_q = '0; m_epend = '0; m_insvc = '0;
        m_req = 1'b0; m_id = '0; m_ack_id = '0; m_hp = '0;
        cyc = 0; last_ack = -100;
    endtask

    task automatic model_next();
        logic            found;
        int              best;
        logic [LP_W-1:0] blp;
        logic [LP_W-1:0] lpv;
        logic            above;
        logic            take;
        found = 1'b0; best = 0; blp = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (m_pending(n) && irq_en[n] && !m_insvc[n]) begin
                lpv = irq_lp[n*LP_W +: LP_W];
                if (!found || lpv > blp) begin
                    found = 1'b1; blp = lpv; best = n;
                end
            end
        end
        above = found && (blp > active);
        take  = ack && m_req;
        nx_irq_q = irq;
        for (int n = 0; n < NUM_IRQ; n++) begin
            nx_epend[n] = (m_epend[n] && !(take && m_id == n)) ||
                          (EDGE_EN && irq_edge[n] && irq[n] && !m_irq_q[n]);
            nx_insvc[n] = (m_insvc[n] && !(eoi_valid && eoi_id == n)) || (take && m_id == n);
        end
        nx_hp       = found ? blp : '0;
        nx_id       = found ? ID_W'(best) : '0;
        nx_ack_id   = m_ack_id;
        nx_last_ack = last_ack;
        if (!m_req) begin
            nx_req = above && ((cyc + 1 - last_ack) >= 2);
        end else if (take) begin
            nx_req      = 1'b0;
            nx_ack_id   = m_id;
            nx_last_ack = cyc + 1;
        end else begin
            nx_req = above;
        end
    endtask

    task automatic compare_all();
        logic [NUM_IRQ-1:0] ep;
        for (int n = 0; n < NUM_IRQ; n++) ep[n] = m_pending(n);
        check("request", req_o, m_req);
        check("irq_id", id_o, m_id);
        check("ack_id", ack_id_o, m_ack_id);
        check("highest_lp", hp_o, m_hp);
        check("pending", pend_o, ep);
        check("in_service", insvc_o, m_insvc);
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        m_irq_q = nx_irq_q; m_epend = nx_epend; m_insvc = nx_insvc;
        m_req = nx_req; m_id = nx_id; m_ack_id = nx_ack_id; m_hp = nx_hp;
        last_ack = nx_last_ack;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_request", req_o, 1'b0);
        check("rst_id", id_o, '0);
        check("rst_ack_id", ack_id_o, '0);
        check("rst_pending", pend_o, '0);
        check("rst_in_service", insvc_o, '0);
        check("rst_highest_lp", hp_o, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        irq = '0; irq_en = '1; irq_edge = '0; irq_lp = '0;
        active = '0; ack = 1'b0; eoi_valid = 1'b0; eoi_id = '0;
    endtask

    initial begin
        logic [NUM_IRQ-1:0] v;
        int r;
        rst = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // Level line 5, LP 3: request two cycles after the line rises
        irq_lp[5*LP_W +: LP_W] = 8'd3;
        irq[5] = 1'b1;
        step();
        check("l5_early", req_o, 1'b0);
        step();
        check("l5_req", req_o, 1'b1);
        check("l5_id", id_o, 8'd5);
        check("l5_hp", hp_o, 8'd3);

        // Tie between lines 2 and 9 goes to 2; then 9 after ack + holdoff
        clear_inputs(); do_reset();
        irq_lp[2*LP_W +: LP_W] = 8'd7;
        irq_lp[9*LP_W +: LP_W] = 8'd7;
        irq[2] = 1'b1; irq[9] = 1'b1;
        step(); step();
        check("tie_id", id_o, 8'd2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("tie_ack_id", ack_id_o, 8'd2);
        check("tie_insvc2", insvc_o[2], 1'b1);
        step();
        check("tie_holdoff", req_o, 1'b0);
        step();
        check("tie_next_req", req_o, 1'b1);
        check("tie_next_id", id_o, 8'd9);

        // Higher-LP arrival replaces the id while the request stays high
        clear_inputs(); do_reset();
        irq_lp[4*LP_W +: LP_W]  = 8'd2;
        irq_lp[10*LP_W +: LP_W] = 8'd6;
        irq[4] = 1'b1;
        step(); step();
        check("pre_id4", id_o, 8'd4);
        irq[10] = 1'b1;
        step(); step();
        check("pre_id10", id_o, 8'd10);
        check("pre_req", req_o, 1'b1);

        // Winner LP must strictly exceed the running level
        clear_inputs(); do_reset();
        irq_lp[1*LP_W +: LP_W] = 8'd4;
        active = 8'd4;
        irq[1] = 1'b1;
        step(); step(); step();
        check("thr_equal", req_o, 1'b0);
        active = 8'd3;
        step();
        check("thr_above", req_o, 1'b1);

`ifdef ZIC_EDGE_TRIG_EN
        // Edge line 3: ack clears pending; a second pulse waits for EOI
        clear_inputs(); do_reset();
        irq_edge[3] = 1'b1;
        irq_lp[3*LP_W +: LP_W] = 8'd5;
        irq[3] = 1'b1;
        step();
        irq[3] = 1'b0;
        step();
        check("edge_req", req_o, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("edge_cleared", pend_o[3], 1'b0);
        irq[3] = 1'b1;
        step();
        irq[3] = 1'b0;
        step(); step(); step();
        check("edge_repend", pend_o[3], 1'b1);
        check("edge_blocked", req_o, 1'b0);
        eoi_valid = 1'b1; eoi_id = 8'd3;
        step();
        eoi_valid = 1'b0;
        step();
        check("edge_after_eoi", req_o, 1'b1);
`endif

        // Asynchronous reset while requesting; EOI of an idle id is ignored
        clear_inputs(); do_reset();
        irq_lp[7*LP_W +: LP_W] = 8'd9;
        irq[7] = 1'b1;
        step(); step();
        check("mid_req", req_o, 1'b1);
        do_reset();
        step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        eoi_valid = 1'b1; eoi_id = 8'd255;
        step();
        eoi_valid = 1'b0;
        v = '0; v[7] = 1'b1;
        check("eoi255_ignored", insvc_o, v);

        // Randomised traffic on lines 0..15 and 255
        clear_inputs(); do_reset();
        for (int n = 0; n < NUM_IRQ; n++) irq_lp[n*LP_W +: LP_W] = LP_W'($urandom_range(0, 15));
        for (int w = 0; w < NUM_IRQ / 32; w++) irq_edge[w*32 +: 32] = $urandom;
        for (int t = 0; t < 1500; t++) begin
            for (int n = 0; n < 16; n++) if ($urandom_range(0, 4) == 0) irq[n] = ~irq[n];
            if ($urandom_range(0, 5) == 0) irq[255] = ~irq[255];
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 15);
                irq_en[r] = ~irq_en[r];
            end
            if ($urandom_range(0, 19) == 0) active = LP_W'($urandom_range(0, 10));
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            eoi_valid = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 3);
            eoi_id = (r == 0) ? 8'd255 : (r == 1) ? ID_W'($urandom_range(0, 255)) : ID_W'($urandom_range(0, 15));
            if (ack && m_req && $urandom_range(0, 2) == 0) begin
                eoi_valid = 1'b1;
                eoi_id    = m_id;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
